// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: latches two 5x5 operand matrices and steps the element
// ALU through them one element pair per cycle, building the result matrix.
// Matrix multiply sweeps the inner index and accumulates partial products.
module matrix_op_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [2:0]   s,
  input  logic [199:0] mat_a,
  input  logic [199:0] mat_b,
  input  logic [7:0]   scalar,
  output logic [2:0]   alu_op,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [2:0]   alu_s,
  input  logic [7:0]   alu_result,
  output logic [199:0] result,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTR = 3'b011;
  localparam logic [2:0] OP_DET   = 3'b100;
  localparam logic [2:0] OP_TRANS = 3'b101;
  localparam logic [2:0] OP_OPP   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [2:0]     n_q, n_d;
  logic [199:0]   a_q, a_d;
  logic [199:0]   b_q, b_d;
  logic [7:0]     scalar_q, scalar_d;
  logic [199:0]   result_q, result_d;
  logic [7:0]     acc_q, acc_d;
  logic [2:0]     i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [2:0]     k_q, k_d;
  logic           err_q, err_d;

  logic [2:0]     last_idx;
  logic [7:0]     mac;
  logic           step_ij;

  // Bit offset of element (r,c) inside a flat row-major 5x5 matrix bus.
  function automatic logic [7:0] elem_base(input logic [2:0] r, input logic [2:0] c);
    return ({5'd0, r} * 8'd5 + {5'd0, c}) * 8'd8;
  endfunction

  function automatic logic [7:0] elem(input logic [199:0] m, input logic [2:0] r,
                                      input logic [2:0] c);
    return m[elem_base(r, c) +: 8];
  endfunction

  assign last_idx = n_q - 3'd1;
  assign mac      = (k_q == 3'd0) ? alu_result : acc_q + alu_result;

  // Present the current element pair to the ALU; the ALU sees zeros outside RUN.
  always_comb begin
    alu_op = 3'd0;
    alu_a  = 8'd0;
    alu_b  = 8'd0;
    if (state_q == RUN) begin
      alu_op = op_q;
      case (op_q)
        OP_MULT: begin
          alu_a = elem(a_q, i_q, k_q);
          alu_b = elem(b_q, k_q, j_q);
        end
        OP_MULTR: begin
          alu_a = elem(a_q, i_q, j_q);
          alu_b = scalar_q;
        end
        OP_TRANS: begin
          alu_a = elem(a_q, j_q, i_q);
          alu_b = 8'd1;
        end
        OP_OPP: begin
          alu_a = elem(a_q, i_q, j_q);
          alu_b = 8'hFF;
        end
        default: begin
          alu_a = elem(a_q, i_q, j_q);
          alu_b = elem(b_q, i_q, j_q);
        end
      endcase
    end
  end

  // Next-state logic: operand capture on start, element sweep, result write-back.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    result_d = result_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    err_d    = err_q;
    step_ij  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          n_d      = s;
          a_d      = mat_a;
          b_d      = mat_b;
          scalar_d = scalar;
          result_d = '0;
          acc_d    = 8'd0;
          i_d      = 3'd0;
          j_d      = 3'd0;
          k_d      = 3'd0;
          err_d    = 1'b0;
          if (op == OP_DET || s < 3'd2 || s > 3'd5) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op == OP_CLEAR) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (op_q == OP_MULT) begin
          acc_d = mac;
          if (k_q == last_idx) begin
            result_d[elem_base(i_q, j_q) +: 8] = mac;
            k_d     = 3'd0;
            step_ij = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else begin
          result_d[elem_base(i_q, j_q) +: 8] = alu_result;
          step_ij = 1'b1;
        end

        if (step_ij) begin
          if (j_q == last_idx) begin
            j_d = 3'd0;
            if (i_q == last_idx) begin
              i_d     = 3'd0;
              state_d = DONE;
            end else begin
              i_d = i_q + 3'd1;
            end
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      n_q      <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= 8'd0;
      result_q <= '0;
      acc_q    <= 8'd0;
      i_q      <= 3'd0;
      j_q      <= 3'd0;
      k_q      <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      err_q    <= err_d;
    end
  end

  assign alu_s  = n_q;
  assign result = result_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign err    = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: drives matrix operations through the sequencer with a
// behavioural element ALU and checks results, timing and ALU traffic against a
// plain-arithmetic reference model of the matrix operations.
module tb_matrix_op_sequencer;

  localparam int BUDGET = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [2:0]   s;
  logic [199:0] mat_a;
  logic [199:0] mat_b;
  logic [7:0]   scalar;
  logic [2:0]   alu_op;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [2:0]   alu_s;
  logic [7:0]   alu_result;
  logic [199:0] result;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  int           obs_done_cycle;
  int           obs_busy_cnt;
  int           obs_alu_idle_bad;
  int           obs_alus_bad;
  bit           obs_reset_hit;
  logic [199:0] obs_result;
  logic         obs_err;
  logic [199:0] obs_after_result;
  logic         obs_after_err;
  logic         obs_after_done;
  logic [18:0]  obs_trace[$];
  logic [18:0]  exp_trace[$];

  matrix_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s(s),
    .mat_a(mat_a), .mat_b(mat_b), .scalar(scalar),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_result), .result(result),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural element ALU: add, subtract, otherwise multiply (low 8 bits).
  assign alu_result = (alu_op == 3'b000) ? alu_a + alu_b :
                      (alu_op == 3'b001) ? alu_a - alu_b : 8'(alu_a * alu_b);

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] raw(input logic [199:0] m, input int r, input int c);
    return m[8*(r*5+c) +: 8];
  endfunction

  function automatic int el(input logic [199:0] m, input int r, input int c);
    logic [7:0] t;
    t = m[8*(r*5+c) +: 8];
    return int'($signed(t));
  endfunction

  // Builds a flat matrix from an n*n list of bytes, first element most significant.
  function automatic logic [199:0] mk(input int n, input logic [199:0] lst);
    logic [199:0] m;
    m = '0;
    for (int t = 0; t < n*n; t++) m[8*((t/n)*5 + t%n) +: 8] = lst[8*(n*n-1-t) +: 8];
    return m;
  endfunction

  function automatic logic [199:0] rand_mat();
    logic [199:0] m;
    for (int t = 0; t < 7; t++) m[t*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic bit model_err(input logic [2:0] o, input int n);
    return (o == 3'd4) || (n < 2) || (n > 5);
  endfunction

  function automatic int model_done(input logic [2:0] o, input int n);
    if (o == 3'd4 || o == 3'd7 || n < 2 || n > 5) return 1;
    if (o == 3'd2) return n*n*n + 1;
    return n*n + 1;
  endfunction

  function automatic logic [199:0] model_result(input logic [2:0] o, input int n,
      input logic [199:0] a, input logic [199:0] b, input logic [7:0] sc);
    logic [199:0] res;
    int v;
    res = '0;
    if (model_done(o, n) == 1) return res;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (o)
          3'd0: v = el(a, i, j) + el(b, i, j);
          3'd1: v = el(a, i, j) - el(b, i, j);
          3'd2: begin
            v = 0;
            for (int k = 0; k < n; k++) v += el(a, i, k) * el(b, k, j);
          end
          3'd3: v = el(a, i, j) * int'($signed(sc));
          3'd5: v = el(a, j, i);
          3'd6: v = -el(a, i, j);
          default: v = 0;
        endcase
        res[8*(i*5+j) +: 8] = v[7:0];
      end
    end
    return res;
  endfunction

  function automatic void model_trace(input logic [2:0] o, input int n,
      input logic [199:0] a, input logic [199:0] b, input logic [7:0] sc);
    exp_trace.delete();
    if (model_done(o, n) == 1) return;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (o)
          3'd2: for (int k = 0; k < n; k++) exp_trace.push_back({o, raw(a, i, k), raw(b, k, j)});
          3'd3: exp_trace.push_back({o, raw(a, i, j), sc});
          3'd5: exp_trace.push_back({o, raw(a, j, i), 8'd1});
          3'd6: exp_trace.push_back({o, raw(a, i, j), 8'hFF});
          default: exp_trace.push_back({o, raw(a, i, j), raw(b, i, j)});
        endcase
      end
    end
  endfunction

  function automatic int trace_diffs();
    int bad;
    bad = (obs_trace.size() != exp_trace.size()) ? 1 : 0;
    for (int t = 0; t < obs_trace.size() && t < exp_trace.size(); t++)
      if (obs_trace[t] !== exp_trace[t]) bad++;
    return bad;
  endfunction

  // Issues one start and records what the DUT does until done (or a reset is forced).
  task automatic run_op(input logic [2:0] op_i, input logic [2:0] s_i,
      input logic [199:0] a_i, input logic [199:0] b_i, input logic [7:0] sc_i,
      input int start_at, input int rst_at);
    obs_trace.delete();
    obs_done_cycle = -1; obs_busy_cnt = 0; obs_alu_idle_bad = 0; obs_alus_bad = 0;
    obs_reset_hit = 0;
    op = op_i; s = s_i; mat_a = a_i; mat_b = b_i; scalar = sc_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (busy === 1'b1) begin
        obs_busy_cnt++;
        obs_trace.push_back({alu_op, alu_a, alu_b});
      end else if ({alu_op, alu_a, alu_b} !== 19'd0) begin
        obs_alu_idle_bad++;
      end
      if (alu_s !== s_i) obs_alus_bad++;
      if (done === 1'b1) begin
        obs_done_cycle = c; obs_result = result; obs_err = err;
        break;
      end
      if (c == start_at) begin
        start = 1'b1; op = 3'd7; s = 3'd2; mat_a = rand_mat(); mat_b = rand_mat();
        scalar = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        obs_reset_hit = 1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (obs_done_cycle > 0) begin
      @(posedge clk); #1;
      obs_after_result = result; obs_after_err = err; obs_after_done = done;
    end
  endtask

  task automatic applyStimulus_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; s = 3'd0; mat_a = '0; mat_b = '0; scalar = 8'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus_reset();
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, err});
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("[TB] FAIL reset_result: got %h expected 0", result);
    end
    checks++;
    if ({alu_op, alu_a, alu_b, alu_s} !== 22'd0) begin
      errors++; $display("[TB] FAIL reset_alu: got %h expected 0", {alu_op, alu_a, alu_b, alu_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(3'd0, 3'd2, mk(2, {8'd1, 8'd2, 8'd3, 8'd4}), mk(2, {8'd10, 8'd20, 8'd30, 8'd40}),
           8'd0, -1, -1);
    checks++;
    if (obs_done_cycle !== 5) begin
      errors++; $display("[TB] FAIL add_done_cycle: got %0d expected 5", obs_done_cycle);
    end
    checks++;
    if (obs_busy_cnt !== 4) begin
      errors++; $display("[TB] FAIL add_busy_cycles: got %0d expected 4", obs_busy_cnt);
    end
    checks++;
    if (obs_result !== mk(2, {8'd11, 8'd22, 8'd33, 8'd44})) begin
      errors++; $display("[TB] FAIL add_result: got %h expected %h", obs_result,
                         mk(2, {8'd11, 8'd22, 8'd33, 8'd44}));
    end
    checks++;
    if (obs_after_result !== obs_result || obs_after_done !== 1'b0) begin
      errors++; $display("[TB] FAIL add_hold: got %h done=%b expected %h done=0",
                         obs_after_result, obs_after_done, obs_result);
    end
  endtask

  task automatic test_multm();
    logic [7:0] pairs [16];
    int bad;
    pairs = '{8'd1, 8'd5, 8'd2, 8'd7, 8'd1, 8'd6, 8'd2, 8'd8,
              8'd3, 8'd5, 8'd4, 8'd7, 8'd3, 8'd6, 8'd4, 8'd8};
    run_op(3'd2, 3'd2, mk(2, {8'd1, 8'd2, 8'd3, 8'd4}), mk(2, {8'd5, 8'd6, 8'd7, 8'd8}),
           8'd0, -1, -1);
    checks++;
    if (obs_done_cycle !== 9) begin
      errors++; $display("[TB] FAIL multm_done_cycle: got %0d expected 9", obs_done_cycle);
    end
    checks++;
    if (obs_result !== mk(2, {8'd19, 8'd22, 8'd43, 8'd50})) begin
      errors++; $display("[TB] FAIL multm_result: got %h expected %h", obs_result,
                         mk(2, {8'd19, 8'd22, 8'd43, 8'd50}));
    end
    bad = (obs_trace.size() != 8) ? 1 : 0;
    for (int t = 0; t < obs_trace.size() && t < 8; t++)
      if (obs_trace[t] !== {3'd2, pairs[2*t], pairs[2*t+1]}) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL multm_alu_sequence: got %0d wrong entries of %0d expected 0",
                         bad, obs_trace.size());
    end
  endtask

  task automatic test_wrap();
    run_op(3'd0, 3'd2, mk(2, {4{8'd100}}), mk(2, {4{8'd100}}), 8'd0, -1, -1);
    checks++;
    if (obs_result !== mk(2, {4{8'hC8}})) begin
      errors++; $display("[TB] FAIL wrap_add: got %h expected %h", obs_result, mk(2, {4{8'hC8}}));
    end
    run_op(3'd6, 3'd2, mk(2, {4{8'h80}}), '0, 8'd0, -1, -1);
    checks++;
    if (obs_result !== mk(2, {4{8'h80}})) begin
      errors++; $display("[TB] FAIL wrap_opp: got %h expected %h", obs_result, mk(2, {4{8'h80}}));
    end
    run_op(3'd3, 3'd2, mk(2, {8'd16, 8'd16, 8'd16, 8'd3}), '0, 8'd16, -1, -1);
    checks++;
    if (obs_result !== mk(2, {8'd0, 8'd0, 8'd0, 8'h30})) begin
      errors++; $display("[TB] FAIL wrap_multmr: got %h expected %h", obs_result,
                         mk(2, {8'd0, 8'd0, 8'd0, 8'h30}));
    end
  endtask

  task automatic test_transm();
    logic [199:0] a;
    a = mk(3, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    run_op(3'd5, 3'd3, a, rand_mat(), 8'd0, -1, -1);
    checks++;
    if (obs_done_cycle !== 10) begin
      errors++; $display("[TB] FAIL trans_done_cycle: got %0d expected 10", obs_done_cycle);
    end
    checks++;
    if (obs_result !== mk(3, {8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9})) begin
      errors++; $display("[TB] FAIL trans_result: got %h expected %h", obs_result,
                         mk(3, {8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9}));
    end
  endtask

  task automatic test_error_paths();
    run_op(3'd4, 3'd3, rand_mat(), rand_mat(), 8'd5, -1, -1);
    checks++;
    if (obs_done_cycle !== 1 || obs_err !== 1'b1 || obs_busy_cnt !== 0) begin
      errors++; $display("[TB] FAIL det_path: got cycle=%0d err=%b busy=%0d expected 1/1/0",
                         obs_done_cycle, obs_err, obs_busy_cnt);
    end
    checks++;
    if (obs_result !== '0) begin
      errors++; $display("[TB] FAIL det_result: got %h expected 0", obs_result);
    end
    run_op(3'd0, 3'd6, rand_mat(), rand_mat(), 8'd0, -1, -1);
    checks++;
    if (obs_err !== 1'b1 || obs_done_cycle !== 1 || obs_after_err !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_size: got err=%b cycle=%0d held=%b expected 1/1/1",
                         obs_err, obs_done_cycle, obs_after_err);
    end
    run_op(3'd0, 3'd2, mk(2, {8'd1, 8'd1, 8'd1, 8'd1}), mk(2, {8'd2, 8'd2, 8'd2, 8'd2}),
           8'd0, -1, -1);
    run_op(3'd7, 3'd4, rand_mat(), rand_mat(), 8'd0, -1, -1);
    checks++;
    if (obs_result !== '0 || obs_err !== 1'b0 || obs_done_cycle !== 1) begin
      errors++; $display("[TB] FAIL clear: got result=%h err=%b cycle=%0d expected 0/0/1",
                         obs_result, obs_err, obs_done_cycle);
    end
  endtask

  task automatic test_start_ignored();
    logic [199:0] a, b;
    a = rand_mat(); b = rand_mat();
    model_trace(3'd2, 5, a, b, 8'd0);
    run_op(3'd2, 3'd5, a, b, 8'd0, 40, -1);
    checks++;
    if (obs_done_cycle !== 126) begin
      errors++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 126", obs_done_cycle);
    end
    checks++;
    if (obs_result !== model_result(3'd2, 5, a, b, 8'd0)) begin
      errors++; $display("[TB] FAIL ignore_result: got %h expected %h", obs_result,
                         model_result(3'd2, 5, a, b, 8'd0));
    end
    checks++;
    if (trace_diffs() != 0) begin
      errors++; $display("[TB] FAIL ignore_alu_trace: got %0d differences expected 0", trace_diffs());
    end
  endtask

  task automatic test_reset_mid_run();
    logic [199:0] a, b;
    run_op(3'd2, 3'd5, rand_mat(), rand_mat(), 8'd0, -1, 30);
    checks++;
    if (obs_reset_hit !== 1'b1 || {busy, done, err} !== 3'b000 || result !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset_state: got hit=%b flags=%b result=%h expected 1/000/0",
                         obs_reset_hit, {busy, done, err}, result);
    end
    checks++;
    if ({alu_op, alu_a, alu_b, alu_s} !== 22'd0) begin
      errors++; $display("[TB] FAIL midrun_reset_alu: got %h expected 0", {alu_op, alu_a, alu_b, alu_s});
    end
    a = rand_mat(); b = rand_mat();
    run_op(3'd1, 3'd3, a, b, 8'd0, -1, -1);
    checks++;
    if (obs_done_cycle !== 10 || obs_result !== model_result(3'd1, 3, a, b, 8'd0)) begin
      errors++; $display("[TB] FAIL midrun_restart: got cycle=%0d result=%h expected 10 / %h",
                         obs_done_cycle, obs_result, model_result(3'd1, 3, a, b, 8'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] a, b;
    run_op(3'd5, 3'd4, rand_mat(), '0, 8'd0, -1, -1);
    a = rand_mat(); b = rand_mat();
    run_op(3'd0, 3'd5, a, b, 8'd0, -1, -1);
    checks++;
    if (obs_done_cycle !== 26 || obs_result !== model_result(3'd0, 5, a, b, 8'd0)) begin
      errors++; $display("[TB] FAIL back_to_back: got cycle=%0d result=%h expected 26 / %h",
                         obs_done_cycle, obs_result, model_result(3'd0, 5, a, b, 8'd0));
    end
  endtask

  task automatic test_random();
    logic [199:0] a, b, exp_res;
    logic [2:0]   o, sz;
    logic [7:0]   sc;
    int           n, exp_done;
    for (int it = 0; it < 25; it++) begin
      o  = 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
      n  = int'(sz);
      a = rand_mat(); b = rand_mat(); sc = 8'($urandom);
      exp_res  = model_result(o, n, a, b, sc);
      exp_done = model_done(o, n);
      model_trace(o, n, a, b, sc);
      run_op(o, sz, a, b, sc, -1, -1);
      checks++;
      if (obs_done_cycle !== exp_done || obs_busy_cnt !== exp_done - 1) begin
        errors++; $display("[TB] FAIL rand_timing op=%0d n=%0d: got done=%0d busy=%0d expected %0d/%0d",
                           o, n, obs_done_cycle, obs_busy_cnt, exp_done, exp_done - 1);
      end
      checks++;
      if (obs_result !== exp_res || obs_err !== model_err(o, n)) begin
        errors++; $display("[TB] FAIL rand_result op=%0d n=%0d: got %h err=%b expected %h err=%b",
                           o, n, obs_result, obs_err, exp_res, model_err(o, n));
      end
      checks++;
      if (trace_diffs() != 0 || obs_alu_idle_bad != 0 || obs_alus_bad != 0) begin
        errors++; $display("[TB] FAIL rand_alu op=%0d n=%0d: got trace_diffs=%0d idle_bad=%0d alu_s_bad=%0d expected 0",
                           o, n, trace_diffs(), obs_alu_idle_bad, obs_alus_bad);
      end
      checks++;
      if (obs_after_result !== exp_res || obs_after_err !== model_err(o, n)) begin
        errors++; $display("[TB] FAIL rand_hold op=%0d: got %h err=%b expected %h err=%b",
                           o, obs_after_result, obs_after_err, exp_res, model_err(o, n));
      end
    end
  endtask

  // Runs every scenario in order, then reports the totals.
  initial begin
    test_reset();
    test_add();
    test_multm();
    test_wrap();
    test_transm();
    test_error_paths();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Control block that drives the matrix coprocessor's combinational element ALU. On a start pulse it latches two 5x5 operand matrices, a scalar, an opcode and a size. It then issues one element-pair per cycle to the ALU and collects each ALU result into a result matrix. For matrix multiply it sweeps the inner index and accumulates the partial products. It sits between the coprocessor's register/bus front end and the ALU instance.

## Interface
- MAXN, 5: fixed storage dimension; element (i,j) occupies bits [8*(i*5+j)+7 : 8*(i*5+j)] of every flat matrix bus.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  3  opcode: 000 addM, 001 subM, 010 multM, 011 multMR, 100 detM, 101 transM, 110 oppM, 111 clear.
- s  in  3  matrix dimension N; valid values 2..5.
- mat_a  in  200  operand A, signed 8-bit elements.
- mat_b  in  200  operand B, signed 8-bit elements.
- scalar  in  8  signed multiplier for multMR.
- alu_op  out  3  opcode to the ALU.
- alu_a, alu_b  out  8  signed ALU operands.
- alu_s  out  3  size to the ALU (latched N).
- alu_result  in  8  signed combinational ALU output.
- result  out  200  result matrix; positions outside NxN are 0.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; held until the next start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Latch op, N, mat_a, mat_b and scalar.
  - Clear result to 0 and clear err.
  - Clear the counters i, j, k.
- Target state after start:
  - op=detM or N outside 2..5: go to DONE, err=1.
  - op=clear: go to DONE, err=0.
  - Otherwise: go to RUN.
- RUN, element ops (one cycle per element, row-major, j fastest):
  - addM, subM: alu_a=A[i][j], alu_b=B[i][j].
  - multMR: alu_a=A[i][j], alu_b=scalar.
  - transM: alu_a=A[j][i], alu_b=1; alu_op driven as 101.
  - oppM: alu_a=A[i][j], alu_b=8'hFF (-1).
  - Each cycle: result[i][j] <= alu_result.
- RUN, multM:
  - Order i, then j, then k (k fastest).
  - alu_a=A[i][k], alu_b=B[k][j].
  - Accumulator acc: acc <= alu_result when k=0, else acc + alu_result.
  - At k=N-1: result[i][j] <= acc + alu_result (alu_result when N=1, which cannot occur).
- Arithmetic: all sums wrap modulo 2^8 (two's complement); no saturation, no overflow flag.
- Leaving RUN: after the last element (i=j=N-1, and k=N-1 for multM) go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Result persistence: result holds until the next accepted start or rst.
- ALU outputs outside RUN: alu_op, alu_a and alu_b are 0; alu_s shows the latched N.
- start while in RUN or DONE: ignored, with no effect on the current operation.
- rst at any time, including mid-RUN:
  - State goes to IDLE; counters and acc are cleared.
  - result=0; busy, done and err=0.
  - alu_* = 0.

## Timing
- Start accepted at edge 0.
- Element ops:
  - RUN occupies cycles 1..N².
  - done is high in cycle N²+1.
- multM:
  - RUN occupies cycles 1..N³.
  - done is high in cycle N³+1.
- detM, clear, or invalid size: done is high in cycle 1; busy never rises.
- result and err are valid in the done cycle and remain stable afterwards.
- start is accepted again in the cycle after done.
- Reset values: busy=0, done=0, err=0, result=0, alu_op=0, alu_a=0, alu_b=0, alu_s=0.

## Test plan
- addM, N=2, A=[1 2;3 4], B=[10 20;30 40]:
  - result = [11 22;33 44].
  - done in cycle 5; busy high in cycles 1-4; positions outside 2x2 read 0.
- multM, N=2, A=[1 2;3 4], B=[5 6;7 8]:
  - result = [19 22;43 50].
  - done in cycle 9; alu_a/alu_b sequence is (1,5),(2,7),(1,6),(2,8)...
- Wrap checks:
  - addM 100+100 gives -56 (8'hC8).
  - oppM of -128 gives -128.
  - multMR 16*scalar 16 gives 0.
- transM, N=3, A=1..9 row-major:
  - result = [1 4 7;2 5 8;3 6 9].
  - done in cycle 10.
- Error and immediate paths:
  - detM with N=3: done in cycle 1, err=1, result=0.
  - addM with s=6: err=1.
  - clear after a prior result: result=0, err=0.
- Control interference during a multM with N=5:
  - start pulsed at cycle 40 is ignored; done still arrives in cycle 126.
  - A separate run with rst at cycle 30: the next cycle is IDLE with all outputs 0, and a fresh start then works normally.
